// File: rtl/game_turn_controller_if.sv
// game_turn_controller_if
//   Bundles the button pulses and projectile feedback going into the turn
//   controller and the state strobes, launch parameters and scores it drives.
//   master : button/datapath side (drives buttons, position, t_air)
//   slave  : game_turn_controller (drives q_*, vX/vY, launch point, scores)
interface game_turn_controller_if;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned TAIR_W  = 50;
    localparam int unsigned VEL_W   = 4;
    localparam int unsigned SCORE_W = 4;

    // Debounced single-cycle button pulses
    logic               btn_fire;
    logic               btn_up;
    logic               btn_down;
    logic               btn_right;
    logic               btn_left;

    // Projectile feedback from the datapath
    logic [COORD_W-1:0] projectileCenterX;
    logic [COORD_W-1:0] projectileCenterY;
    logic [TAIR_W-1:0]  t_air;

    // One-hot state strobes
    logic               q_Init;
    logic               q_Aim;
    logic               q_P1Shoot;
    logic               q_Animate;
    logic               q_Result;
    logic               q_GameOver;

    // Launch parameters, turn and score
    logic [VEL_W-1:0]   vX;
    logic [VEL_W-1:0]   vY;
    logic [COORD_W-1:0] X_INITIAL;
    logic [COORD_W-1:0] Y_INITIAL;
    logic               player;
    logic [SCORE_W-1:0] scoreP1;
    logic [SCORE_W-1:0] scoreP2;
    logic               lastHit;

    modport master (
        output btn_fire, btn_up, btn_down, btn_right, btn_left,
        output projectileCenterX, projectileCenterY, t_air,
        input  q_Init, q_Aim, q_P1Shoot, q_Animate, q_Result, q_GameOver,
        input  vX, vY, X_INITIAL, Y_INITIAL, player, scoreP1, scoreP2, lastHit
    );

    modport slave (
        input  btn_fire, btn_up, btn_down, btn_right, btn_left,
        input  projectileCenterX, projectileCenterY, t_air,
        output q_Init, q_Aim, q_P1Shoot, q_Animate, q_Result, q_GameOver,
        output vX, vY, X_INITIAL, Y_INITIAL, player, scoreP1, scoreP2, lastHit
    );
endinterface

// File: rtl/game_turn_controller.sv
// game_turn_controller
//   Turn sequencer for the projectile game: aims the launch velocity, strobes
//   shoot/animate into the projectile datapath, classifies each shot (hit,
//   out-of-bounds, ground, timeout), holds the result on screen and keeps
//   per-player scores.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      game_turn_controller_if.slave (buttons, projectile feedback in;
//            one-hot state strobes, vX/vY, launch point, player, scores out)
// Build option:
//   TWO_PLAYER_EN  when defined, turns alternate between two cannons and
//                  scoreP2 counts player 2's hits; otherwise player stays 0.
module game_turn_controller #(
    parameter int unsigned TGT_X_MIN   = 650,
    parameter int unsigned TGT_X_MAX   = 675,
    parameter int unsigned TGT_Y_MIN   = 470,
    parameter int unsigned TGT_Y_MAX   = 475,
    parameter int unsigned GROUND_Y    = 475,
    parameter int unsigned LEFT_X      = 155,
    parameter int unsigned RIGHT_X     = 775,
    parameter int unsigned TOP_Y       = 50,
    parameter int unsigned T_AIR_MAX   = 40,
    parameter int unsigned RESULT_HOLD = 100000000,
    parameter int unsigned SCORE_MAX   = 9,
    parameter int unsigned P1_X        = 207,
    parameter int unsigned P1_Y        = 462,
    parameter int unsigned P2_X        = 260,
    parameter int unsigned P2_Y        = 462
) (
    input  logic                   clk,
    input  logic                   reset_n,
    game_turn_controller_if.slave  bus
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SUM_W   = 11;
    localparam int unsigned TAIR_W  = 50;
    localparam int unsigned VEL_W   = 4;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned HOLD_W  = 32;

    localparam logic [VEL_W-1:0]   VEL_MAX  = VEL_W'(15);
    localparam logic [VEL_W-1:0]   VX_INIT  = VEL_W'(5);
    localparam logic [VEL_W-1:0]   VY_INIT  = VEL_W'(10);
    localparam logic [SCORE_W-1:0] SC_MAX   = SCORE_W'(SCORE_MAX);
    localparam logic [HOLD_W-1:0]  HOLD_END = HOLD_W'(RESULT_HOLD);
    localparam logic [SUM_W-1:0]   Y_WRAP   = SUM_W'(1000);

    // One-hot encoding so each q_* output is a flop bit with no decode
    typedef enum logic [5:0] {
        S_INIT      = 6'b000001,
        S_AIM       = 6'b000010,
        S_SHOOT     = 6'b000100,
        S_ANIMATE   = 6'b001000,
        S_RESULT    = 6'b010000,
        S_GAME_OVER = 6'b100000
    } state_t;

    state_t             r_state;
    logic [VEL_W-1:0]   r_vx;
    logic [VEL_W-1:0]   r_vy;
    logic [SCORE_W-1:0] r_score_p1;
    logic [SCORE_W-1:0] r_score_p2;
    logic               r_player;
    logic               r_last_hit;
    logic               r_anim_first;
    logic [HOLD_W-1:0]  r_hold;

    logic [SUM_W-1:0]   w_x;
    logic [SUM_W-1:0]   w_y;
    logic [SUM_W-1:0]   w_x5;
    logic [SUM_W-1:0]   w_y2;
    logic               w_hit;
    logic               w_out;
    logic               w_ground;
    logic               w_timeout;
    logic               w_event;
    logic [VEL_W-1:0]   w_vx_next;
    logic [VEL_W-1:0]   w_vy_next;
    logic               w_credit;
    logic [SCORE_W-1:0] w_p1_next;
    logic [SCORE_W-1:0] w_p2_next;
    logic               w_game_over;

    // Shot classification on the live datapath position, 11-bit sums
    assign w_x       = SUM_W'(bus.projectileCenterX);
    assign w_y       = SUM_W'(bus.projectileCenterY);
    assign w_x5      = w_x + SUM_W'(5);
    assign w_y2      = w_y + SUM_W'(2);
    assign w_hit     = (w_x5 >= SUM_W'(TGT_X_MIN)) && (w_x <= SUM_W'(TGT_X_MAX)) &&
                       (w_y2 >= SUM_W'(TGT_Y_MIN)) && (w_y <= SUM_W'(TGT_Y_MAX));
    // Y >= 1000 catches the unsigned wrap when the shell leaves the top
    assign w_out     = (w_x5 >= SUM_W'(RIGHT_X)) || (w_x <= SUM_W'(LEFT_X)) ||
                       (w_y <= SUM_W'(TOP_Y)) || (w_y >= Y_WRAP);
    assign w_ground  = (w_y2 >= SUM_W'(GROUND_Y));
    assign w_timeout = (bus.t_air >= TAIR_W'(T_AIR_MAX));
    assign w_event   = w_hit || w_out || w_ground || w_timeout;

    // Saturating velocity adjust; opposing pulses cancel
    always_comb begin
        w_vx_next = r_vx;
        w_vy_next = r_vy;
        if (bus.btn_right && !bus.btn_left && (r_vx != VEL_MAX))
            w_vx_next = r_vx + VEL_W'(1);
        else if (bus.btn_left && !bus.btn_right && (r_vx != '0))
            w_vx_next = r_vx - VEL_W'(1);
        if (bus.btn_up && !bus.btn_down && (r_vy != VEL_MAX))
            w_vy_next = r_vy + VEL_W'(1);
        else if (bus.btn_down && !bus.btn_up && (r_vy != '0))
            w_vy_next = r_vy - VEL_W'(1);
    end

    // Score credit on the first RESULT cycle; game-over test sees the new score
    assign w_credit = (r_state == S_RESULT) && (r_hold == '0) && r_last_hit;

    always_comb begin
        w_p1_next = r_score_p1;
        w_p2_next = '0;
        if (w_credit && !r_player && (r_score_p1 < SC_MAX))
            w_p1_next = r_score_p1 + SCORE_W'(1);
`ifdef TWO_PLAYER_EN
        w_p2_next = r_score_p2;
        if (w_credit && r_player && (r_score_p2 < SC_MAX))
            w_p2_next = r_score_p2 + SCORE_W'(1);
`endif
    end

    assign w_game_over = (w_p1_next == SC_MAX) || (w_p2_next == SC_MAX);

    // Game state machine with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_INIT;
            r_vx         <= VX_INIT;
            r_vy         <= VY_INIT;
            r_score_p1   <= '0;
            r_score_p2   <= '0;
            r_player     <= 1'b0;
            r_last_hit   <= 1'b0;
            r_anim_first <= 1'b0;
            r_hold       <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_vx       <= VX_INIT;
                    r_vy       <= VY_INIT;
                    r_score_p1 <= '0;
                    r_score_p2 <= '0;
                    r_player   <= 1'b0;
                    r_last_hit <= 1'b0;
                    r_hold     <= '0;
                    r_state    <= S_AIM;
                end
                S_AIM: begin
                    r_vx <= w_vx_next;
                    r_vy <= w_vy_next;
                    if (bus.btn_fire)
                        r_state <= S_SHOOT;
                end
                S_SHOOT: begin
                    r_anim_first <= 1'b1;
                    r_state      <= S_ANIMATE;
                end
                S_ANIMATE: begin
                    // First cycle skipped: datapath still reloading position
                    if (r_anim_first) begin
                        r_anim_first <= 1'b0;
                    end else if (w_event) begin
                        r_last_hit <= w_hit;
                        r_hold     <= '0;
                        r_state    <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    r_score_p1 <= w_p1_next;
                    r_score_p2 <= w_p2_next;
                    if (r_hold == HOLD_END) begin
                        r_hold <= '0;
                        if (w_game_over) begin
                            r_state <= S_GAME_OVER;
                        end else begin
                            r_state <= S_AIM;
`ifdef TWO_PLAYER_EN
                            r_player <= ~r_player;
`endif
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                S_GAME_OVER: begin
                    if (bus.btn_fire)
                        r_state <= S_INIT;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign bus.q_Init     = r_state[0];
    assign bus.q_Aim      = r_state[1];
    assign bus.q_P1Shoot  = r_state[2];
    assign bus.q_Animate  = r_state[3];
    assign bus.q_Result   = r_state[4];
    assign bus.q_GameOver = r_state[5];
    assign bus.vX         = r_vx;
    assign bus.vY         = r_vy;
    assign bus.player     = r_player;
    assign bus.scoreP1    = r_score_p1;
    assign bus.scoreP2    = r_score_p2;
    assign bus.lastHit    = r_last_hit;
    // Launch point follows the active player combinationally
    assign bus.X_INITIAL  = r_player ? COORD_W'(P2_X) : COORD_W'(P1_X);
    assign bus.Y_INITIAL  = r_player ? COORD_W'(P2_Y) : COORD_W'(P1_Y);

endmodule

// File: doc/game_turn_controller.md
# game_turn_controller

Turn sequencer for the projectile datapath: owns the game state machine, holds the launch velocity being aimed, and pulses the shoot and animate strobes into the projectile renderer/animator. It watches the projectile position and flight time each cycle and classifies the shot as hit, ground, out-of-bounds or timeout. It also keeps per-player scores and, optionally, alternates turns between two cannons. It sits between the debounced button block and the VGA projectile/bit-change block.

## Interface
Parameters:
- TGT_X_MIN, 650, target left edge (px)
- TGT_X_MAX, 675, target right edge
- TGT_Y_MIN, 470, target top edge
- TGT_Y_MAX, 475, target bottom edge
- GROUND_Y, 475, ground plane top
- LEFT_X / RIGHT_X / TOP_Y, 155 / 775 / 50, play-field border lines
- T_AIR_MAX, 40, flight-step timeout
- RESULT_HOLD, 100000000, clocks spent showing the result (1 s at 100 MHz)
- SCORE_MAX, 9, winning score
- P1_X / P1_Y, 207 / 462, player-1 launch point
- P2_X / P2_Y, 260 / 462, player-2 launch point

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- btn_fire  in  1  single-cycle debounced pulse
- btn_up / btn_down  in  1  single-cycle pulses; adjust vY
- btn_right / btn_left  in  1  single-cycle pulses; adjust vX
- projectileCenterX / projectileCenterY  in  10  projectile top-left from the datapath
- t_air  in  50  flight steps from the datapath
- q_Init, q_Aim, q_P1Shoot, q_Animate, q_Result, q_GameOver  out  1  one-hot state outputs
- vX / vY  out  4  launch velocity components
- X_INITIAL / Y_INITIAL  out  10  active player's launch point
- player  out  1  0 = P1, 1 = P2
- scoreP1 / scoreP2  out  4  scores
- lastHit  out  1  outcome of the most recent shot (1 = hit)

## Operation
- States: INIT → AIM → SHOOT → ANIMATE → RESULT → (AIM | GAME_OVER).
- INIT (1 cycle): clears both scores, lastHit and player to 0; loads vX = 5, vY = 10; goes to AIM.
- AIM:
  - btn_up / btn_down change vY by ±1; btn_right / btn_left change vX by ±1.
  - Both saturate at 0 and 15.
  - Simultaneous opposing pulses leave the value unchanged.
  - btn_fire → SHOOT. If btn_fire arrives together with adjust pulses, the adjustments are applied in that same cycle.
- SHOOT: lasts exactly 1 cycle; q_P1Shoot is high (the datapath reloads the position and clears t_air); always goes to ANIMATE.
- ANIMATE: evaluated every cycle on the input values, using 11-bit sums throughout.
  - Evaluation is held off for the first ANIMATE cycle so the datapath has reloaded its position.
  - hit: X+5 ≥ TGT_X_MIN, X ≤ TGT_X_MAX, Y+2 ≥ TGT_Y_MIN and Y ≤ TGT_Y_MAX.
  - out: X+5 ≥ RIGHT_X, X ≤ LEFT_X, Y ≤ TOP_Y, or Y ≥ 1000 (catches wrap above the screen).
  - ground: Y+2 ≥ GROUND_Y.
  - timeout: t_air ≥ T_AIR_MAX.
  - Priority is hit > out > ground > timeout. Any event → RESULT; lastHit = hit.
- RESULT:
  - On entry, a hit increments the active player's score, saturating at SCORE_MAX.
  - Hold counter runs RESULT_HOLD cycles.
  - Then: if any score equals SCORE_MAX → GAME_OVER; otherwise → AIM and, when enabled, player toggles.
- GAME_OVER: outputs hold; btn_fire → INIT; all other buttons ignored.
- X_INITIAL / Y_INITIAL are P1_X/P1_Y when player = 0, else P2_X/P2_Y. They are combinational from player.
- Buttons pressed outside AIM and GAME_OVER are ignored.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = INIT, so q_Init = 1 and all other q_* = 0.
  - vX = 5, vY = 10, scores = 0, player = 0, lastHit = 0, hold counter = 0.
- All state outputs are registered; exactly one is high every cycle.
- Latencies:
  - fire pulse → q_P1Shoot high on the next cycle, for exactly 1 cycle.
  - q_Animate follows on the next cycle.
  - Event detection → q_Result on the next edge.
  - Score is visible 1 cycle after q_Result rises.
- RESULT lasts RESULT_HOLD + 1 cycles.
- Reset asserted mid-flight returns to INIT immediately; the datapath stops animating because q_Animate drops.

## Configuration
- TWO_PLAYER_EN defined: player toggles at each RESULT→AIM transition; scoreP2 counts player 2's hits.
- Undefined: player is tied to 0, scoreP2 is constant 0, and X_INITIAL / Y_INITIAL are always P1_X / P1_Y.

## Test plan
- Reset, then 3× btn_up and 6× btn_left in AIM → vY = 13, vX = 0 (saturated); 3 more btn_up → vY = 15.
- btn_fire with position forced to X = 655, Y = 468 → q_P1Shoot 1 cycle, q_Animate, then q_Result with lastHit = 1 and scoreP1 = 1.
- Position X = 400, Y = 474 → ground; lastHit = 0, score unchanged. Same with Y = 1010 → out classification.
- Position X = 660, Y = 474 (hit and ground both true) → hit wins, scoreP1 increments.
- t_air = 40 with position in open field → timeout; after RESULT_HOLD (reduced to 10 in the bench) state returns to AIM, and player = 1 with TWO_PLAYER_EN.
- Nine hits → GAME_OVER holds; btn_fire → INIT, scores cleared. Assert reset_n low during ANIMATE → q_Init the same cycle.
